mips_cpu_lsu: RTL and testbench
===============================

Name: mips_cpu_lsu

Overview:
Load/store unit sitting directly downstream of the CPU control FSM (mips_cpu_bus) and upstream of the Avalon-MM data bus. It takes one memory instruction per request and drives the Avalon master signals, honouring waitrequest. It performs byte-lane steering and byteenable generation for stores, and sign/zero extension and LWL/LWR merging for loads. It returns a registered result with a one-cycle done pulse, so the core FSM only waits on done.

Parameters:
RESET_RESULT, 32'h00000000, value of result after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request strobe; sampled only in IDLE
op  in  6  MIPS primary opcode: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011
addr  in  32  effective byte address (rs + sign-extended immediate)
store_data  in  32  rt value for stores
rt_old  in  32  current rt value, used for LWL/LWR merge
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; misaligned access or illegal op
result  out  32  load result; holds its value until the next load completes
address  out  32  Avalon address, always {addr_q[31:2],2'b00}
read  out  1  Avalon read request
write  out  1  Avalon write request
waitrequest  in  1  Avalon stall
writedata  out  32  Avalon write data
byteenable  out  4  Avalon byte lanes; bit0 = bits 7:0 = lowest byte address (little-endian)
readdata  in  32  valid in the cycle after read acceptance

Behaviour:
- Reset (synchronous, reset=1 at a clk edge): state=IDLE; busy=0, done=0, err=0, read=0, write=0, byteenable=0, writedata=0, address=0, result=RESET_RESULT. Reset overrides any in-flight transaction. read/write are low from the first cycle after the reset edge. No done pulse is issued for an aborted request.
- States: IDLE, REQ, RDATA, DONE.
- IDLE: when start=1, latch op, addr, store_data, rt_old.
  - Illegal op, or misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to DONE with err=1. No bus cycle.
  - Otherwise go to REQ.
- REQ: read=1 (loads) or write=1 (stores), held stable until a cycle with waitrequest=0 (acceptance).
  - On acceptance: loads go to RDATA, stores go to DONE.
  - The address, writedata and byteenable outputs do not change while stalled.
- RDATA: sample readdata, compute and register result, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored whenever busy=1.
- Latency with zero wait states (start at cycle T): store done at T+2; load done at T+3; error done at T+1. Each waitrequest cycle adds 1.
- Stores (b = addr[1:0]):
  - SB: writedata={4{sd[7:0]}}, byteenable=1<<b.
  - SH: writedata={2{sd[15:0]}}, byteenable = b[1] ? 1100 : 0011.
  - SW: writedata=sd, byteenable=1111.
- Load byteenable: LB/LBU 1<<b; LH/LHU 0011 or 1100; LW/LWL/LWR 1111.
- Load extraction (w = readdata):
  - LB/LBU: byte w[8b+7:8b], sign- or zero-extended.
  - LH/LHU: half w[16*b[1]+15:16*b[1]], sign- or zero-extended.
  - LW: w.
  - LWL: b=0 {w[7:0],rt[23:0]}; b=1 {w[15:0],rt[15:0]}; b=2 {w[23:0],rt[7:0]}; b=3 w.
  - LWR: b=0 w; b=1 {rt[31:24],w[31:8]}; b=2 {rt[31:16],w[31:16]}; b=3 {rt[31:8],w[31:24]}.
- Stores and error completions leave result unchanged.
- read and write are never high together. Both are low outside REQ.

Test Plan:
- LW addr=0x00001004, waitrequest=0, readdata=0xDEADBEEF -> address=0x00001004, byteenable=1111; done at T+3, err=0, result=0xDEADBEEF.
- LB addr=0x00001003, readdata=0x80FF1234 -> byteenable=1000, result=0xFFFFFF80. LBU at the same address -> result=0x00000080.
- SH addr=0x00002002, store_data=0x1234ABCD, waitrequest high for 3 cycles -> write held 4 cycles with address=0x00002000, writedata=0xABCDABCD, byteenable=1100 stable throughout; done at T+5.
- LH addr=0x00000001 -> done at T+1 with err=1, read never asserted. Op 6'b111111 gives the same result.
- LWL addr=...1, rt_old=0x11223344, readdata=0xAABBCCDD -> result=0xCCDD3344. LWR addr=...1 -> result=0x11AABBCC.
- Assert reset while in REQ with waitrequest=1 -> read=0 the cycle after the reset edge, busy=0, no done pulse, result=RESET_RESULT.

Source files
------------

// File: rtl/mips_cpu_lsu_if.sv
// Signal bundle around the load/store unit: the core-side request/response
// and the Avalon-MM data bus.
// master : the LSU's view (it masters the Avalon bus and answers the core)
// slave  : the surroundings' view (core control FSM plus memory)
interface mips_cpu_lsu_if;
  // core side
  logic        start;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  // Avalon-MM side
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  start, op, addr, store_data, rt_old, waitrequest, readdata,
    output busy, done, err, result, address, read, write, writedata, byteenable
  );

  modport slave (
    output start, op, addr, store_data, rt_old, waitrequest, readdata,
    input  busy, done, err, result, address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: one memory instruction per request, Avalon-MM master
// with waitrequest, store lane steering, load extension and LWL/LWR merge.
module mips_cpu_lsu #(
  parameter logic [31:0] RESET_RESULT = 32'h00000000
) (
  input logic           clk,
  input logic           reset,
  mips_cpu_lsu_if.master bus
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] rt_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        err_q;
  logic        is_store_q;
  logic [31:0] result_q;

  // decode of the incoming request (only consumed in IDLE)
  logic        dec_legal;
  logic        dec_misalign;
  logic        dec_store;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic        dec_err;

  // load datapath
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;

  // Split the read word into byte lanes so a lane can be picked by addr[1:0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = bus.readdata[8*gi +: 8];
    end
  endgenerate

  // Classify the request, and build store lanes/byteenables up front so they
  // are registered once and stay frozen while the bus stalls.
  always_comb begin
    dec_legal    = 1'b0;
    dec_misalign = 1'b0;
    dec_store    = 1'b0;
    dec_be       = 4'b0000;
    dec_wdata    = 32'h0;
    case (bus.op)
      OP_LB, OP_LBU: begin
        dec_legal = 1'b1;
        dec_be    = 4'b0001 << bus.addr[1:0];
      end
      OP_LH, OP_LHU: begin
        dec_legal    = 1'b1;
        dec_misalign = bus.addr[0];
        dec_be       = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW: begin
        dec_legal    = 1'b1;
        dec_misalign = (bus.addr[1:0] != 2'b00);
        dec_be       = 4'b1111;
      end
      OP_LWL, OP_LWR: begin
        dec_legal = 1'b1;
        dec_be    = 4'b1111;
      end
      OP_SB: begin
        dec_legal = 1'b1;
        dec_store = 1'b1;
        dec_be    = 4'b0001 << bus.addr[1:0];
        dec_wdata = {4{bus.store_data[7:0]}};
      end
      OP_SH: begin
        dec_legal    = 1'b1;
        dec_store    = 1'b1;
        dec_misalign = bus.addr[0];
        dec_be       = bus.addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {2{bus.store_data[15:0]}};
      end
      OP_SW: begin
        dec_legal    = 1'b1;
        dec_store    = 1'b1;
        dec_misalign = (bus.addr[1:0] != 2'b00);
        dec_be       = 4'b1111;
        dec_wdata    = bus.store_data;
      end
      default: ;
    endcase
    dec_err = !dec_legal || dec_misalign;
  end

  // Extract, extend or merge the returned word according to the latched op.
  always_comb begin
    sel_byte    = rd_byte[addr_q[1:0]];
    sel_half    = addr_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    load_result = result_q;
    case (op_q)
      OP_LB:  load_result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: load_result = {24'h0, sel_byte};
      OP_LH:  load_result = {{16{sel_half[15]}}, sel_half};
      OP_LHU: load_result = {16'h0, sel_half};
      OP_LW:  load_result = bus.readdata;
      OP_LWL: begin
        case (addr_q[1:0])
          2'd0:    load_result = {bus.readdata[7:0],  rt_q[23:0]};
          2'd1:    load_result = {bus.readdata[15:0], rt_q[15:0]};
          2'd2:    load_result = {bus.readdata[23:0], rt_q[7:0]};
          default: load_result = bus.readdata;
        endcase
      end
      OP_LWR: begin
        case (addr_q[1:0])
          2'd0:    load_result = bus.readdata;
          2'd1:    load_result = {rt_q[31:24], bus.readdata[31:8]};
          2'd2:    load_result = {rt_q[31:16], bus.readdata[31:16]};
          default: load_result = {rt_q[31:8],  bus.readdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  // Next-state: errors skip the bus, stores finish on acceptance, loads
  // take one more cycle to capture readdata.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = dec_err ? S_DONE : S_REQ;
      S_REQ:   if (!bus.waitrequest) state_d = is_store_q ? S_DONE : S_RDATA;
      S_RDATA: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight access without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request capture in IDLE and result capture in RDATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 6'h0;
      addr_q     <= 32'h0;
      rt_q       <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      err_q      <= 1'b0;
      is_store_q <= 1'b0;
      result_q   <= RESET_RESULT;
    end else begin
      if (state_q == S_IDLE && bus.start) begin
        op_q       <= bus.op;
        addr_q     <= bus.addr;
        rt_q       <= bus.rt_old;
        wdata_q    <= dec_wdata;
        be_q       <= dec_be;
        err_q      <= dec_err;
        is_store_q <= dec_store;
      end
      if (state_q == S_RDATA) result_q <= load_result;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_DONE) && err_q;
  assign bus.result     = result_q;
  assign bus.address    = {addr_q[31:2], 2'b00};
  assign bus.read       = (state_q == S_REQ) && !is_store_q;
  assign bus.write      = (state_q == S_REQ) && is_store_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = be_q;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu: a stimulus process pushes expected
// responses from a word-level memory model, a randomly stalling Avalon slave
// serves the bus, and a monitor compares whatever the DUT presents.
module tb_mips_cpu_lsu;

  localparam logic [31:0] RST_VAL = 32'h0BADF00D;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef struct {
    logic        err;
    logic        is_store;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] address;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] result;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_lsu_if bus();

  mips_cpu_lsu #(.RESET_RESULT(RST_VAL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_stalls = 0;
  int          force_stalls = -1;
  logic [31:0] ref_result = RST_VAL;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h required %08h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic logic [31:0] init_word(logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] slv_rd(logic [31:0] wa);
    if (slv_mem.exists(wa)) return slv_mem[wa];
    return init_word(wa);
  endfunction

  task automatic set_word(input logic [31:0] wa, input logic [31:0] v);
    ref_mem[wa] = v;
    slv_mem[wa] = v;
  endtask

  // Reference model: MIPS memory-instruction semantics on a word memory.
  task automatic model(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rt,
                       output exp_t e);
    int          b;
    logic [31:0] w, wa, tmp, m;
    logic [7:0]  by;
    logic [15:0] hw;
    logic [63:0] keep;
    int          sh;
    bit          is_ld, is_st, bad;
    b  = int'(addr[1:0]);
    wa = {addr[31:2], 2'b00};
    w  = ref_rd(wa);
    e.op = op; e.addr = addr; e.address = wa;
    e.err = 1'b0; e.is_store = 1'b0; e.be = 4'h0; e.wdata = 32'h0;
    e.result = ref_result; e.lat = 0; e.start_cyc = 0;
    is_ld = op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    is_st = op inside {OP_SB, OP_SH, OP_SW};
    bad = !(is_ld || is_st)
          || ((op inside {OP_LH, OP_LHU, OP_SH}) && (b % 2 != 0))
          || ((op inside {OP_LW, OP_SW}) && (b != 0));
    if (bad) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (is_ld) begin
      e.lat = 3;
      tmp = w >> (8 * b);        by = tmp[7:0];
      tmp = w >> (16 * (b / 2)); hw = tmp[15:0];
      case (op)
        OP_LB:  e.result = {{24{by[7]}}, by};
        OP_LBU: e.result = {24'h0, by};
        OP_LH:  e.result = {{16{hw[15]}}, hw};
        OP_LHU: e.result = {16'h0, hw};
        OP_LW:  e.result = w;
        OP_LWL: begin
          keep = (64'd1 << (8 * (3 - b))) - 64'd1;
          e.result = (w << (8 * (3 - b))) | (rt & keep[31:0]);
        end
        default: e.result = (w >> (8 * b)) | (rt & ~(32'hFFFFFFFF >> (8 * b)));
      endcase
      if (op inside {OP_LB, OP_LBU})      e.be = 4'b0001 << b;
      else if (op inside {OP_LH, OP_LHU}) e.be = (b >= 2) ? 4'b1100 : 4'b0011;
      else                                e.be = 4'b1111;
      ref_result = e.result;
    end else begin
      e.lat = 2;
      e.is_store = 1'b1;
      case (op)
        OP_SB: begin
          m = 32'hFF; sh = 8 * b;
          e.wdata = {24'h0, sd[7:0]} * 32'h01010101;
          e.be = 4'b0001 << b;
        end
        OP_SH: begin
          m = 32'hFFFF; sh = 16 * (b / 2);
          e.wdata = {16'h0, sd[15:0]} * 32'h00010001;
          e.be = (b >= 2) ? 4'b1100 : 4'b0011;
        end
        default: begin
          m = 32'hFFFFFFFF; sh = 0;
          e.wdata = sd;
          e.be = 4'b1111;
        end
      endcase
      ref_mem[wa] = (w & ~(m << sh)) | ((sd & m) << sh);
    end
  endtask

  // Avalon slave: random (or forced) stalls, readdata the cycle after accept.
  always @(negedge clk) begin : responder
    logic [31:0] tw;
    logic        pend_rd;
    logic [31:0] pend_wa;
    logic        req_prev;
    int          stall_left;
    if (pend_rd === 1'b1) begin
      bus.readdata = slv_rd(pend_wa);
      pend_rd = 1'b0;
    end else begin
      bus.readdata = $urandom;
    end
    if (bus.read || bus.write) begin
      if (req_prev !== 1'b1)
        stall_left = (force_stalls >= 0) ? force_stalls
                   : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      if (stall_left > 0) begin
        bus.waitrequest = 1'b1;
        stall_left--;
        n_stalls++;
        req_prev = 1'b1;
      end else begin
        bus.waitrequest = 1'b0;
        req_prev = 1'b0;
        if (bus.write) begin
          tw = slv_rd(bus.address);
          for (int i = 0; i < 4; i++)
            if (bus.byteenable[i]) tw[8*i +: 8] = bus.writedata[8*i +: 8];
          slv_mem[bus.address] = tw;
        end else begin
          pend_rd = 1'b1;
          pend_wa = bus.address;
        end
      end
    end else begin
      bus.waitrequest = 1'($urandom_range(0, 1));
      req_prev = 1'b0;
    end
  end

  // Monitor: bus request fields while requesting, response on done.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b0) begin
      check("rw_exclusive", {31'h0, bus.read & bus.write}, 32'h0);
      if (bus.read || bus.write) begin
        if (exp_q.size() == 0) begin
          check("req_without_txn", {30'h0, bus.read, bus.write}, 32'h0);
        end else begin
          e = exp_q[0];
          if (e.err) begin
            check("req_on_error", {30'h0, bus.read, bus.write}, 32'h0);
          end else begin
            check("address", bus.address, e.address);
            check("byteenable", {28'h0, bus.byteenable}, {28'h0, e.be});
            check("read", {31'h0, bus.read}, {31'h0, !e.is_store});
            check("write", {31'h0, bus.write}, {31'h0, e.is_store});
            if (e.is_store) check("writedata", bus.writedata, e.wdata);
          end
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_without_txn", {31'h0, bus.done}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("err", {31'h0, bus.err}, {31'h0, e.err});
          check("result", bus.result, e.result);
          check("latency", cyc - e.start_cyc, e.lat + n_stalls);
          $display("txn op=%06b addr=%08h err=%0d result=%08h stalls=%0d",
                   e.op, e.addr, bus.err, bus.result, n_stalls);
          n_stalls = 0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    n_stalls = 0;
    force_stalls = -1;
    ref_result = RST_VAL;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic randomize_inputs();
    bus.op         = 6'($urandom);
    bus.addr       = $urandom;
    bus.store_data = $urandom;
    bus.rt_old     = $urandom;
  endtask

  // Issue one request from an idle DUT and wait (bounded) for its done.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rt,
                       input int stalls, input bit hold2);
    exp_t e;
    int   t;
    bit   seen;
    force_stalls = stalls;
    model(op, addr, sd, rt, e);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.addr = addr;
    bus.store_data = sd; bus.rt_old = rt;
    @(posedge clk); #1;
    randomize_inputs();
    bus.start = hold2;
    t = 0; seen = 1'b0;
    while (!seen && t < 60) begin
      @(negedge clk);
      seen = bus.done;
      @(posedge clk); #1;
      bus.start = 1'b0;
      t++;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done after %0d cycles, op=%06b addr=%08h", t, op, addr);
      do_reset();
    end
    force_stalls = -1;
  endtask

  initial begin : watchdog
    repeat (100000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [5:0] ops [10];
    logic [5:0] op;
    ops = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW};
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 6'h0; bus.addr = 32'h0; bus.store_data = 32'h0; bus.rt_old = 32'h0;
    bus.waitrequest = 1'b0; bus.readdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    check("rst_read", {31'h0, bus.read}, 32'h0);
    check("rst_write", {31'h0, bus.write}, 32'h0);
    check("rst_byteenable", {28'h0, bus.byteenable}, 32'h0);
    check("rst_writedata", bus.writedata, 32'h0);
    check("rst_address", bus.address, 32'h0);
    check("rst_result", bus.result, RST_VAL);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // directed cases
    set_word(32'h00001004, 32'hDEADBEEF);
    issue(OP_LW, 32'h00001004, $urandom, $urandom, 0, 1'b0);
    set_word(32'h00001000, 32'h80FF1234);
    issue(OP_LB, 32'h00001003, $urandom, $urandom, 0, 1'b0);
    issue(OP_LBU, 32'h00001003, $urandom, $urandom, 0, 1'b0);
    issue(OP_SH, 32'h00002002, 32'h1234ABCD, $urandom, 3, 1'b0);
    issue(OP_LH, 32'h00000001, $urandom, $urandom, 0, 1'b0);
    issue(6'b111111, 32'h00001000, $urandom, $urandom, 0, 1'b1);
    set_word(32'h00003000, 32'hAABBCCDD);
    issue(OP_LWL, 32'h00003001, $urandom, 32'h11223344, 0, 1'b0);
    issue(OP_LWR, 32'h00003001, $urandom, 32'h11223344, 0, 1'b0);
    issue(OP_LW, 32'h00002000, $urandom, $urandom, 0, 1'b0);

    // randomized traffic over a small window so loads see earlier stores
    for (int n = 0; n < 300; n++) begin
      int k;
      k  = int'($urandom_range(0, 11));
      op = (k < 10) ? ops[k] : 6'($urandom);
      issue(op, 32'h00001000 + 32'($urandom_range(0, 31)), $urandom, $urandom,
            -1, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset while a load is stalled in REQ
    begin
      exp_t e;
      force_stalls = 10;
      model(OP_LW, 32'h00001008, 32'h0, 32'h0, e);
      e.start_cyc = cyc;
      exp_q.push_back(e);
      bus.start = 1'b1; bus.op = OP_LW; bus.addr = 32'h00001008;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("abort_read_before", {31'h0, bus.read}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_q.delete();
      ref_result = RST_VAL;
      @(posedge clk);
      @(negedge clk);
      check("abort_read", {31'h0, bus.read}, 32'h0);
      check("abort_busy", {31'h0, bus.busy}, 32'h0);
      check("abort_done", {31'h0, bus.done}, 32'h0);
      check("abort_result", bus.result, RST_VAL);
      n_stalls = 0;
      force_stalls = -1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end

    issue(OP_LW, 32'h00001008, $urandom, $urandom, 1, 1'b0);
    issue(OP_SB, 32'h00001009, $urandom, $urandom, 0, 1'b0);
    issue(OP_LWR, 32'h0000100A, $urandom, $urandom, 0, 1'b0);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
